// File: rtl/conv_result_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_writer_pkg
// Description : Shared types and geometry helpers for the conv result writer.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_result_writer_pkg;

    localparam int c_CONV_DATA_W = 48;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int calc_out_size(input int fm, input int k, input int p, input int s);
        return ((fm - k + 2 * p) / s) + 1;
    endfunction

    // Odd pooled sizes drop the trailing row/column.
    function automatic int calc_wr_size(input int out_size, input int maxpool);
        return (maxpool != 0) ? (out_size / 2) : out_size;
    endfunction

    function automatic int calc_addr_w(input int fm, input int k, input int p, input int s,
                                       input int maxpool);
        int wr;
        wr = calc_wr_size(calc_out_size(fm, k, p, s), maxpool);
        return clog2_min1(wr * wr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/conv_result_writer_pool_line_buf.sv
`default_nettype none
// ============================================================================
// Module      : pool_line_buf
// Description : One-row buffer of horizontal pool maxima; 1 write, 1 async read.
// Revision    : 1.0 - initial release
// ============================================================================
module pool_line_buf #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 48,
    parameter int ADDR_W = 1
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [ADDR_W-1:0]        i_waddr,
    input  logic signed [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]        i_raddr,
    output logic signed [DATA_W-1:0] o_rdata
);

    logic signed [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : conv_result_writer
// Description : Collects raster conv results, optionally 2x2 max-pools them,
//               and writes them to the output BRAM; flags layer completion.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_result_writer
    import conv_result_writer_pkg::*;
#(
    parameter int  KERNEL_SIZE = 3,
    parameter int  FM_SIZE     = 5,
    parameter int  PADDING     = 0,
    parameter int  STRIDE      = 1,
    parameter int  MAXPOOL     = 0,
    parameter int  DATA_W      = c_CONV_DATA_W,
    localparam int c_ADDR_W    = calc_addr_w(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE, MAXPOOL)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_go,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_conv_result,
    output logic                     o_wr_en,
    output logic [c_ADDR_W-1:0]      o_wr_addr,
    output logic signed [DATA_W-1:0] o_wr_data,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_overflow
);

    localparam int c_OUT_SIZE = calc_out_size(FM_SIZE, KERNEL_SIZE, PADDING, STRIDE);
    localparam int c_WR_SIZE  = calc_wr_size(c_OUT_SIZE, MAXPOOL);
    localparam int c_N_WORDS  = c_WR_SIZE * c_WR_SIZE;
    localparam int c_CNT_W    = clog2_min1(c_OUT_SIZE);

    localparam logic [c_CNT_W-1:0]  c_LAST_IDX  = c_CNT_W'(c_OUT_SIZE - 1);
    localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(c_N_WORDS - 1);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_start;
    logic                     w_accept;
    logic                     w_wr_fire;
    logic signed [DATA_W-1:0] w_wr_value;
    logic [c_CNT_W-1:0]       r_row;
    logic [c_CNT_W-1:0]       r_col;
    logic [c_ADDR_W-1:0]      r_addr;
    logic                     r_wr_en;
    logic [c_ADDR_W-1:0]      r_wr_addr;
    logic signed [DATA_W-1:0] r_wr_data;
    logic                     r_overflow;

    // A go pulse outside COLLECT starts a layer and swallows any same-cycle i_en.
    assign w_start  = i_go && (r_state != ST_COLLECT);
    assign w_accept = i_en && (r_state == ST_COLLECT);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (i_go) w_state_nxt = ST_COLLECT;
            ST_COLLECT: if (r_wr_en && (r_wr_addr == c_LAST_ADDR)) w_state_nxt = ST_DONE;
            ST_DONE:    if (i_go) w_state_nxt = ST_COLLECT;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_accept) begin
            if (r_col == c_LAST_IDX) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST_IDX) ? '0 : r_row + c_CNT_W'(1);
            end else begin
                r_col <= r_col + c_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_addr    <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_start) begin
                r_addr <= '0;
            end else if (w_wr_fire) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_wr_value;
                r_addr    <= r_addr + c_ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_start) begin
            r_overflow <= 1'b0;
        end else if ((r_state == ST_DONE) && i_en) begin
            r_overflow <= 1'b1;
        end
    end

    generate
        if (MAXPOOL != 0) begin : g_pool
            localparam int c_LB_AW    = clog2_min1(c_WR_SIZE);
            localparam int c_POOL_LIM = 2 * c_WR_SIZE;

            logic signed [DATA_W-1:0] r_hold;
            logic signed [DATA_W-1:0] w_h;
            logic signed [DATA_W-1:0] w_lb_rd;
            logic [c_LB_AW-1:0]       w_lb_idx;
            logic                     w_in_range;
            logic                     w_lb_we;

            assign w_in_range = (int'(r_row) < c_POOL_LIM) && (int'(r_col) < c_POOL_LIM);
            assign w_h        = (i_conv_result > r_hold) ? i_conv_result : r_hold;
            assign w_lb_idx   = c_LB_AW'(r_col >> 1);
            assign w_lb_we    = w_accept && w_in_range && r_col[0] && !r_row[0];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_hold <= '0;
                end else if (w_accept && !r_col[0]) begin
                    r_hold <= i_conv_result;
                end
            end

            pool_line_buf #(
                .DEPTH  (c_WR_SIZE),
                .DATA_W (DATA_W),
                .ADDR_W (c_LB_AW)
            ) u_line_buf (
                .i_clk   (i_clk),
                .i_we    (w_lb_we),
                .i_waddr (w_lb_idx),
                .i_wdata (w_h),
                .i_raddr (w_lb_idx),
                .o_rdata (w_lb_rd)
            );

            // Bottom-right sample of a 2x2 window completes it.
            assign w_wr_fire  = w_accept && w_in_range && r_col[0] && r_row[0];
            assign w_wr_value = (w_lb_rd > w_h) ? w_lb_rd : w_h;
        end else begin : g_raw
            assign w_wr_fire  = w_accept;
            assign w_wr_value = i_conv_result;
        end
    endgenerate

    assign o_wr_en    = r_wr_en;
    assign o_wr_addr  = r_wr_addr;
    assign o_wr_data  = r_wr_data;
    assign o_busy     = (r_state == ST_COLLECT);
    assign o_done     = (r_state == ST_DONE);
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_conv_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_result_writer
// Description : Randomized self-checking bench for conv_result_writer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_writer;

    localparam int c_DW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst;
    logic                   go     [3];
    logic                   en     [3];
    logic signed [c_DW-1:0] din    [3];
    logic                   wr_en_v[3];
    logic                   busy_v [3];
    logic                   done_v [3];
    logic                   ovf_v  [3];
    logic signed [c_DW-1:0] data_v [3];
    logic [3:0]             a0;
    logic [1:0]             a1;
    logic [1:0]             a2;

    // Instance 0: raw 3x3, instance 1: pooled 4x4, instance 2: pooled odd 5x5.
    int osz[3] = '{3, 4, 5};
    int mp [3] = '{0, 1, 1};

    conv_result_writer #(.KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1),
                         .MAXPOOL(0), .DATA_W(c_DW)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_go(go[0]), .i_en(en[0]), .i_conv_result(din[0]),
        .o_wr_en(wr_en_v[0]), .o_wr_addr(a0), .o_wr_data(data_v[0]),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_overflow(ovf_v[0]));

    conv_result_writer #(.KERNEL_SIZE(3), .FM_SIZE(6), .PADDING(0), .STRIDE(1),
                         .MAXPOOL(1), .DATA_W(c_DW)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_go(go[1]), .i_en(en[1]), .i_conv_result(din[1]),
        .o_wr_en(wr_en_v[1]), .o_wr_addr(a1), .o_wr_data(data_v[1]),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_overflow(ovf_v[1]));

    conv_result_writer #(.KERNEL_SIZE(3), .FM_SIZE(7), .PADDING(0), .STRIDE(1),
                         .MAXPOOL(1), .DATA_W(c_DW)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_go(go[2]), .i_en(en[2]), .i_conv_result(din[2]),
        .o_wr_en(wr_en_v[2]), .o_wr_addr(a2), .o_wr_data(data_v[2]),
        .o_busy(busy_v[2]), .o_done(done_v[2]), .o_overflow(ovf_v[2]));

    int     n_tests = 0;
    int     n_fail  = 0;
    int     cyc     = 0;
    int     got_n      [3];
    int     got_addr   [3][64];
    longint got_data   [3][64];
    int     last_wr_cyc[3];
    int     done_cyc   [3];
    logic   done_prev  [3];
    longint samp       [64];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int addr_of(input int d);
        case (d)
            0:       return int'(a0);
            1:       return int'(a1);
            default: return int'(a2);
        endcase
    endfunction

    // Write/done monitor, sampled 1 time unit after each rising edge.
    initial begin
        for (int d = 0; d < 3; d++) begin
            got_n[d] = 0; last_wr_cyc[d] = -1; done_cyc[d] = -1; done_prev[d] = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int d = 0; d < 3; d++) begin
                if (wr_en_v[d] === 1'b1) begin
                    if (got_n[d] < 64) begin
                        got_addr[d][got_n[d]] = addr_of(d);
                        got_data[d][got_n[d]] = longint'(data_v[d]);
                    end
                    got_n[d]++;
                    last_wr_cyc[d] = cyc;
                end
                if (done_v[d] === 1'b1 && done_prev[d] !== 1'b1) done_cyc[d] = cyc;
                done_prev[d] = done_v[d];
            end
        end
    end

    function automatic longint sext48(input logic [47:0] v);
        logic signed [47:0] s;
        s = v;
        return longint'(s);
    endfunction

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 7))
                0:       samp[i] = 64'sh0000_7FFF_FFFF_FFFF;
                1:       samp[i] = -64'sh0000_8000_0000_0000;
                2:       samp[i] = longint'($urandom_range(0, 20)) - 10;
                default: samp[i] = sext48({$urandom(), $urandom()});
            endcase
        end
    endtask

    // Reference: raw raster write-out, or 2x2 signed max over the kept region.
    task automatic check_layer(input int d, input string tag);
        int     wr;
        int     nexp;
        int     o;
        longint m;
        wr   = (mp[d] != 0) ? osz[d] / 2 : osz[d];
        nexp = wr * wr;
        o    = osz[d];
        check_eq($sformatf("%s_nwrites", tag), got_n[d], nexp);
        for (int k = 0; k < nexp && k < got_n[d] && k < 64; k++) begin
            if (mp[d] != 0) begin
                int pr;
                int pc;
                pr = k / wr;
                pc = k % wr;
                m  = samp[(2 * pr) * o + 2 * pc];
                for (int dr = 0; dr < 2; dr++)
                    for (int dc = 0; dc < 2; dc++)
                        if (samp[(2 * pr + dr) * o + 2 * pc + dc] > m)
                            m = samp[(2 * pr + dr) * o + 2 * pc + dc];
            end else begin
                m = samp[k];
            end
            check_eq($sformatf("%s_addr%0d", tag, k), got_addr[d][k], k);
            check_eq($sformatf("%s_data%0d", tag, k), got_data[d][k], m);
        end
        check_eq($sformatf("%s_done_lat", tag), done_cyc[d] - last_wr_cyc[d], 1);
        check_eq($sformatf("%s_done", tag), done_v[d], 1);
        check_eq($sformatf("%s_busy", tag), busy_v[d], 0);
    endtask

    task automatic run_layer(input int d, input int gap, input bit mid_go,
                             input bit go_with_en, input string tag);
        int n;
        int k;
        n = osz[d] * osz[d];
        got_n[d] = 0; done_cyc[d] = -1; last_wr_cyc[d] = -1;
        @(negedge clk);
        go[d] = 1'b1;
        if (go_with_en) begin
            en[d]  = 1'b1;
            din[d] = 48'sh7FFF_FFFF_FFF0;
        end
        @(negedge clk);
        go[d] = 1'b0; en[d] = 1'b0;
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            en[d]  = 1'b1;
            din[d] = samp[i][c_DW-1:0];
            if (mid_go && i == n / 2) go[d] = 1'b1;
            @(negedge clk);
            en[d] = 1'b0; go[d] = 1'b0;
        end
        k = 0;
        while (done_v[d] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        check_layer(d, tag);
    endtask

    task automatic check_all_zero(input int d, input string tag);
        check_eq($sformatf("%s_wr_en", tag), wr_en_v[d], 0);
        check_eq($sformatf("%s_addr", tag), addr_of(d), 0);
        check_eq($sformatf("%s_data", tag), longint'(data_v[d]), 0);
        check_eq($sformatf("%s_busy", tag), busy_v[d], 0);
        check_eq($sformatf("%s_done", tag), done_v[d], 0);
        check_eq($sformatf("%s_ovf", tag), ovf_v[d], 0);
    endtask

    initial begin
        int snap;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            go[d] = 1'b0; en[d] = 1'b0; din[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) check_all_zero(d, $sformatf("reset%0d", d));
        rst = 1'b0;

        // i_en while idle is ignored
        @(negedge clk);
        en[1] = 1'b1; din[1] = 48'sd5;
        repeat (3) @(negedge clk);
        en[1] = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_en_nwr", got_n[1], 0);
        check_eq("idle_en_busy", busy_v[1], 0);

        for (int i = 0; i < 9; i++) samp[i] = longint'(i + 1);
        run_layer(0, 0, 1'b0, 1'b0, "t1");

        // Extra results after completion
        snap = got_n[0];
        for (int i = 0; i < 2; i++) begin
            en[0] = 1'b1; din[0] = 48'sd77;
            @(negedge clk);
            en[0] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check_eq("t5_nowrite", got_n[0], snap);
        check_eq("t5_ovf", ovf_v[0], 1);
        check_eq("t5_done_held", done_v[0], 1);
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        check_eq("t5_ovf_clr", ovf_v[0], 0);
        check_eq("t5_done_clr", done_v[0], 0);
        check_eq("t5_busy", busy_v[0], 1);
        fill_rand(9);
        run_layer(0, 0, 1'b0, 1'b0, "t5_next");

        for (int i = 0; i < 16; i++) samp[i] = longint'(i);
        run_layer(1, 0, 1'b0, 1'b0, "t2");
        for (int i = 0; i < 16; i++) samp[i] = -longint'(i);
        run_layer(1, 0, 1'b0, 1'b0, "t3");

        for (int i = 0; i < 9; i++) samp[i] = longint'(i + 1);
        run_layer(0, 2, 1'b1, 1'b0, "t4");

        fill_rand(9);
        run_layer(0, 0, 1'b0, 1'b1, "goen0");
        fill_rand(16);
        run_layer(1, 1, 1'b0, 1'b1, "goen1");

        for (int r = 0; r < 3; r++) begin
            fill_rand(9);
            run_layer(0, int'($urandom_range(0, 2)), r[0], 1'b0, $sformatf("rnd0_%0d", r));
            fill_rand(16);
            run_layer(1, int'($urandom_range(0, 2)), r[0], 1'b0, $sformatf("rnd1_%0d", r));
            fill_rand(25);
            run_layer(2, int'($urandom_range(0, 2)), r[0], 1'b0, $sformatf("rnd2_%0d", r));
        end

        // Reset mid-layer, then a fresh layer
        @(negedge clk);
        go[0] = 1'b1;
        @(negedge clk);
        go[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            en[0] = 1'b1; din[0] = 48'sd100 + 48'(i);
            @(negedge clk);
            en[0] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero(0, "t6_rst");
        fill_rand(9);
        run_layer(0, 0, 1'b0, 1'b0, "t6_fresh");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
